piso_serializer: RTL and testbench

//   Parallel-in/serial-out transmitter built on a bank of D flip-flops. Accepts one

---
 rtl/piso_serializer.sv | 176 +++++++++++++++++
 tb/tb_piso_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. One WIDTH-bit word is taken per
// valid/ready handshake and shifted out one bit per clk, framed by ser_frame
// and terminated by a single-cycle ser_last pulse. A word accepted on the
// final cycle of a frame follows with no idle gap.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: in_data[WIDTH-1] goes out first; 0: in_data[0] first
//
// Ports
//   clk        single clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to send
//   in_data    word to serialize, sampled only on handshake
//   in_ready   block can accept a word this cycle
//   ser_out    serial data bit (registered)
//   ser_frame  high on every cycle ser_out carries a frame bit (registered)
//   ser_last   high on the final bit of a frame (registered)
//
// Build option
//   SERIALIZER_PARITY_EN  when defined, each frame carries one extra even
//                         parity bit (^word) after the last data bit, and
//                         ser_last / in_ready mark that parity cycle.
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int CW   = $clog2(WIDTH) + 1;
  // Bit position of the shift register that is currently on the wire.
  localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count_reg, count_next;
  logic             frame_reg, frame_next;
  logic             last_reg, last_next;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic accept;
  logic last_data;
  logic frame_end;

  // The shift register always holds the bit on the wire at HEAD, so ser_out
  // is a direct flop output; idle and reset leave the register cleared.
  assign ser_out   = shift_reg[HEAD];
  assign ser_frame = frame_reg;
  assign ser_last  = last_reg;

  // last_reg is high exactly on the final cycle of a frame, which is also
  // the only non-idle cycle in which a new word may be taken.
  assign in_ready  = (state_reg == IDLE) || last_reg;
  assign accept    = in_valid && in_ready;
  assign last_data = (state_reg == SHIFT) && (count_reg == CW'(WIDTH - 1));

`ifdef SERIALIZER_PARITY_EN
  assign frame_end = (state_reg == PARITY);
`else
  assign frame_end = last_data;
`endif

  // Register contents moved one place toward HEAD, zero filled.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    count_next  = count_reg;
    frame_next  = frame_reg;
    last_next   = last_reg;
`ifdef SERIALIZER_PARITY_EN
    parity_next = parity_reg;
`endif

    if ((state_reg == IDLE) || frame_end) begin
      if (accept) begin
        // Load puts the first bit on the wire on the very next cycle.
        state_next  = SHIFT;
        shift_next  = in_data;
        count_next  = '0;
        frame_next  = 1'b1;
        last_next   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_next = ^in_data;
`endif
      end else begin
        state_next = IDLE;
        shift_next = '0;
        count_next = '0;
        frame_next = 1'b0;
        last_next  = 1'b0;
      end
    end else if (state_reg == SHIFT) begin
`ifdef SERIALIZER_PARITY_EN
      if (last_data) begin
        state_next       = PARITY;
        shift_next       = '0;
        shift_next[HEAD] = parity_reg;
        count_next       = '0;
        last_next        = 1'b1;
      end else begin
        shift_next = shifted;
        count_next = count_reg + 1'b1;
        last_next  = 1'b0;
      end
`else
      shift_next = shifted;
      count_next = count_reg + 1'b1;
      // Raise ser_last as the final data bit moves onto the wire.
      last_next  = (count_reg == CW'(WIDTH - 2));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      count_reg  <= '0;
      frame_reg  <= 1'b0;
      last_reg   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      count_reg  <= count_next;
      frame_reg  <= frame_next;
      last_reg   <= last_next;
`ifdef SERIALIZER_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives an MSB-first and an LSB-first instance from the same handshake and
// compares both against a queue-based frame model built from the word value.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;

  logic rdy_m, out_m, frm_m, lst_m;
  logic rdy_l, out_l, frm_l, lst_l;

  int checks   = 0;
  int failures = 0;

  // Model: queues of {bit, last} still to appear; cur_* is what is on the wire.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic       cur_v = 1'b0;
  logic [1:0] cur_m = 2'b00;
  logic [1:0] cur_l = 2'b00;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_m), .ser_out(out_m), .ser_frame(frm_m), .ser_last(lst_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_l), .ser_out(out_l), .ser_frame(frm_l), .ser_last(lst_l)
  );

  // One clock cycle: check in_ready, let the edge pass, advance the model,
  // then check the serial outputs of both instances.
  task automatic step();
    logic         exp_rdy;
    logic         acc;
    logic         rst_s;
    logic [W-1:0] w;
    logic [2:0]   exp_m;
    logic [2:0]   exp_l;
    exp_rdy = !cur_v || cur_m[0];
    checks++;
    if ({rdy_m, rdy_l} !== {exp_rdy, exp_rdy}) begin
      failures++;
      $display("FAIL in_ready t=%0t got m=%b l=%b expected %b", $time, rdy_m, rdy_l, exp_rdy);
    end
    rst_s = rst_n;
    acc   = rst_n && in_valid && exp_rdy;
    w     = in_data;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      q_m.delete();
      q_l.delete();
      cur_v = 1'b0;
    end else begin
      if (acc) begin
        for (int i = 0; i < FRAME; i++) begin
          logic bm, bl;
          bm = (i < W) ? w[W-1-i] : ^w;
          bl = (i < W) ? w[i]     : ^w;
          q_m.push_back({bm, i == FRAME - 1});
          q_l.push_back({bl, i == FRAME - 1});
        end
      end
      if (q_m.size() > 0) begin
        cur_v = 1'b1;
        cur_m = q_m.pop_front();
        cur_l = q_l.pop_front();
      end else begin
        cur_v = 1'b0;
      end
    end
    exp_m = cur_v ? {cur_m[1], 1'b1, cur_m[0]} : 3'b000;
    exp_l = cur_v ? {cur_l[1], 1'b1, cur_l[0]} : 3'b000;
    checks++;
    if ({out_m, frm_m, lst_m} !== exp_m) begin
      failures++;
      $display("FAIL serial_msb t=%0t got out/frame/last=%b expected %b", $time, {out_m, frm_m, lst_m}, exp_m);
    end
    checks++;
    if ({out_l, frm_l, lst_l} !== exp_l) begin
      failures++;
      $display("FAIL serial_lsb t=%0t got out/frame/last=%b expected %b", $time, {out_l, frm_l, lst_l}, exp_l);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_m, out_m, frm_m, lst_m, rdy_l, out_l, frm_l, lst_l} !== 8'b1000_1000) begin
      failures++;
      $display("FAIL reset_async got m=%b%b%b%b l=%b%b%b%b expected 1000 1000",
               rdy_m, out_m, frm_m, lst_m, rdy_l, out_l, frm_l, lst_l);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  // Sends one word from idle and rebuilds the data bits seen on each wire.
  task automatic test_single(input logic [W-1:0] w, input string name);
    logic [W-1:0] got_m;
    logic [W-1:0] got_l;
    got_m = '0;
    got_l = '0;
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    for (int i = 0; i < W; i++) begin
      got_m = {got_m[W-2:0], out_m};
      got_l[i] = out_l;
      if (i < W - 1) step();
    end
    checks++;
    if (got_m !== w) begin
      failures++;
      $display("FAIL %s_msb_word got %h expected %h", name, got_m, w);
    end
    checks++;
    if (got_l !== w) begin
      failures++;
      $display("FAIL %s_lsb_word got %h expected %h", name, got_l, w);
    end
    repeat (FRAME - W + 2) step();
    $display("test_single %s word=%h done failures=%0d", name, w, failures);
  endtask

  task automatic test_back_to_back();
    int ones, lasts, drops;
    ones = 0; lasts = 0; drops = 0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_data  = 8'h00;
    for (int i = 0; i < 2 * FRAME; i++) begin
      ones  += int'(out_m);
      lasts += int'(lst_m);
      drops += int'(!frm_m);
      if (i == FRAME) in_valid = 1'b0;
      if (i < 2 * FRAME - 1) step();
    end
    in_valid = 1'b0;
    checks++;
    if (ones != 8 || lasts != 2 || drops != 0) begin
      failures++;
      $display("FAIL back_to_back got ones=%0d lasts=%0d drops=%0d expected 8 2 0", ones, lasts, drops);
    end
    repeat (3) step();
    $display("test_back_to_back done failures=%0d", failures);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_m, out_m, frm_m, lst_m, rdy_l, out_l, frm_l, lst_l} !== 8'b1000_1000) begin
      failures++;
      $display("FAIL reset_mid got m=%b%b%b%b l=%b%b%b%b expected 1000 1000",
               rdy_m, out_m, frm_m, lst_m, rdy_l, out_l, frm_l, lst_l);
    end
    q_m.delete();
    q_l.delete();
    cur_v = 1'b0;
    // A handshake offered while reset is held must be dropped.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    repeat (2) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    repeat (FRAME + 2) step();
    $display("test_reset_mid done failures=%0d", failures);
  endtask

  task automatic test_parity_pair();
    in_valid = 1'b1;
    in_data  = 8'h07;
    step();
    in_data  = 8'h03;
    repeat (FRAME) step();
    in_valid = 1'b0;
    repeat (FRAME + 2) step();
    $display("test_parity_pair done failures=%0d", failures);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (FRAME + 2) step();
    $display("test_random done failures=%0d", failures);
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "a5");
    test_single(8'h01, "01");
    test_back_to_back();
    test_reset_mid();
    test_parity_pair();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
